// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master: FSM states, command codes, frame sizes.
package spi_pkg;

  localparam int FRAME_BITS = 10;
  localparam int DATA_BITS  = 8;

  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } spi_cmd_e;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    CMD,
    SHIFT,
    WAIT,
    RECV,
    FINISH,
    GAP
  } spi_state_e;

endpackage

// File: rtl/spi_master_shifter.sv
// Datapath for the SPI master: TX frame shift register, RX byte shift register, shared bit counter.
module spi_master_shifter
  import spi_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [FRAME_BITS-1:0] tx_word,
  input  logic                  tx_shift,
  input  logic                  rx_shift,
  input  logic                  miso,
  input  logic                  cnt_load,
  input  logic [3:0]            cnt_init,
  input  logic                  cnt_dec,
  output logic                  tx_bit,
  output logic [DATA_BITS-1:0]  rx_next,
  output logic [3:0]            cnt
);

  logic [FRAME_BITS-1:0] tx_sr;
  logic [DATA_BITS-1:0]  rx_sr;
  logic                  unused_rx_msb;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_sr <= '0;
      rx_sr <= '0;
      cnt   <= '0;
    end else begin
      if (load)
        tx_sr <= tx_word;
      else if (tx_shift)
        tx_sr <= {tx_sr[FRAME_BITS-2:0], 1'b0};
      if (rx_shift)
        rx_sr <= rx_next;
      if (cnt_load)
        cnt <= cnt_init;
      else if (cnt_dec)
        cnt <= cnt - 4'd1;
    end
  end

  assign tx_bit  = tx_sr[FRAME_BITS-1];
  // The byte including the bit arriving this cycle, so the FSM can publish it on the last sample edge.
  assign rx_next = {rx_sr[DATA_BITS-2:0], miso};
  assign unused_rx_msb = rx_sr[DATA_BITS-1];

endmodule

// File: rtl/spi_master.sv
// SPI master: sends a 10-bit command/address/data frame and, for read-data commands, receives one byte.
module spi_master
  import spi_pkg::*;
#(
  parameter int READ_LATENCY = 3,
  parameter int IDLE_GAP     = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [FRAME_BITS-1:0] tx_word,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_BITS-1:0]  rd_data,
  output logic                  rd_valid,
  output logic                  SS_n,
  output logic                  MOSI,
  input  logic                  MISO
);

  spi_state_e state, next_state;
  spi_cmd_e   cmd_q;

  logic                 load, tx_shift, rx_shift, cnt_load, cnt_dec;
  logic [3:0]           cnt_init, cnt;
  logic                 tx_bit;
  logic [DATA_BITS-1:0] rx_next;
  logic                 ss_active_next, mosi_next, finish_next;

  spi_master_shifter u_shifter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .tx_word  (tx_word),
    .tx_shift (tx_shift),
    .rx_shift (rx_shift),
    .miso     (MISO),
    .cnt_load (cnt_load),
    .cnt_init (cnt_init),
    .cnt_dec  (cnt_dec),
    .tx_bit   (tx_bit),
    .rx_next  (rx_next),
    .cnt      (cnt)
  );

  always_comb begin
    next_state = state;
    load       = 1'b0;
    rx_shift   = 1'b0;
    cnt_load   = 1'b0;
    cnt_init   = '0;
    cnt_dec    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = SELECT;
          load       = 1'b1;
        end
      end
      SELECT: next_state = CMD;
      CMD: begin
        next_state = SHIFT;
        cnt_load   = 1'b1;
        cnt_init   = 4'(FRAME_BITS);
      end
      SHIFT: begin
        cnt_dec = 1'b1;
        if (cnt == 4'd1) begin
          if (cmd_q == CMD_RD_DATA) begin
            next_state = WAIT;
            cnt_load   = 1'b1;
            cnt_init   = 4'(READ_LATENCY);
          end else begin
            next_state = FINISH;
          end
        end
      end
      WAIT: begin
        cnt_dec = 1'b1;
        if (cnt == 4'd1) begin
          next_state = RECV;
          cnt_load   = 1'b1;
          cnt_init   = 4'(DATA_BITS);
        end
      end
      RECV: begin
        rx_shift = 1'b1;
        cnt_dec  = 1'b1;
        if (cnt == 4'd1)
          next_state = FINISH;
      end
      FINISH: begin
        next_state = GAP;
        cnt_load   = 1'b1;
        cnt_init   = 4'(IDLE_GAP);
      end
      GAP: begin
        cnt_dec = 1'b1;
        if (cnt == 4'd1)
          next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase

    // Pin values are registered from the state being entered so they line up with that state.
    tx_shift       = (next_state == SHIFT);
    ss_active_next = (next_state inside {SELECT, CMD, SHIFT, WAIT, RECV});
    mosi_next      = (next_state == CMD || next_state == SHIFT) ? tx_bit : 1'b0;
    finish_next    = (next_state == FINISH);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cmd_q    <= CMD_WR_ADDR;
      SS_n     <= 1'b1;
      MOSI     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      state    <= next_state;
      if (load)
        cmd_q <= spi_cmd_e'(tx_word[FRAME_BITS-1 -: 2]);
      SS_n     <= !ss_active_next;
      MOSI     <= mosi_next;
      busy     <= (next_state != IDLE);
      done     <= finish_next;
      rd_valid <= finish_next && (cmd_q == CMD_RD_DATA);
      if (finish_next && cmd_q == CMD_RD_DATA)
        rd_data <= rx_next;
    end
  end

endmodule
